// File: rtl/avalon_st_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one Avalon-ST sink between two sources.
// The grant is locked from the first accepted beat until that source's Eop beat is accepted.
module avalon_st_pkt_arbiter #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ERROR_WIDTH = 1,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                   Clk_CI,
   input  logic                   Rst_RBI,

   input  logic                   In0Valid_SI,
   input  logic                   In0Sop_SI,
   input  logic                   In0Eop_SI,
   input  logic [1:0]             In0Empty_SI,
   input  logic [ERROR_WIDTH-1:0] In0Error_SI,
   input  logic [DATA_WIDTH-1:0]  In0Data_DI,
   output logic                   In0Ready_SO,

   input  logic                   In1Valid_SI,
   input  logic                   In1Sop_SI,
   input  logic                   In1Eop_SI,
   input  logic [1:0]             In1Empty_SI,
   input  logic [ERROR_WIDTH-1:0] In1Error_SI,
   input  logic [DATA_WIDTH-1:0]  In1Data_DI,
   output logic                   In1Ready_SO,

   output logic                   OutValid_SO,
   output logic                   OutSop_SO,
   output logic                   OutEop_SO,
   output logic [1:0]             OutEmpty_SO,
   output logic [ERROR_WIDTH-1:0] OutError_SO,
   output logic [DATA_WIDTH-1:0]  OutData_DO,
   input  logic                   OutReady_SI,

   output logic [1:0]             Grant_SO,
   output logic [CNT_WIDTH-1:0]   PktCnt0_DO,
   output logic [CNT_WIDTH-1:0]   PktCnt1_DO
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StBusy0 = 2'd1,
      StBusy1 = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic                   last_grant_q, last_grant_d;  // 0: source 0 was last, 1: source 1
   logic [1:0]             grant_q, grant_d;
   logic [CNT_WIDTH-1:0]   cnt0_q, cnt0_d;
   logic [CNT_WIDTH-1:0]   cnt1_q, cnt1_d;

   logic                   eop_acc0, eop_acc1;

   assign eop_acc0 = (state_q == StBusy0) & In0Valid_SI & OutReady_SI & In0Eop_SI;
   assign eop_acc1 = (state_q == StBusy1) & In1Valid_SI & OutReady_SI & In1Eop_SI;

   // Next-state: arbitration in idle, release on accepted Eop.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;
      grant_d      = 2'b00;

      case (state_q)
         StIdle: begin
            if (In0Valid_SI && (!In1Valid_SI || last_grant_q)) begin
               state_d      = StBusy0;
               last_grant_d = 1'b0;
            end else if (In1Valid_SI) begin
               state_d      = StBusy1;
               last_grant_d = 1'b1;
            end
         end
         StBusy0: begin
            if (eop_acc0) begin
               state_d = StIdle;
               cnt0_d  = cnt0_q + 1'b1;
            end
         end
         StBusy1: begin
            if (eop_acc1) begin
               state_d = StIdle;
               cnt1_d  = cnt1_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      case (state_d)
         StBusy0: grant_d = 2'b01;
         StBusy1: grant_d = 2'b10;
         default: grant_d = 2'b00;
      endcase
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         grant_q      <= 2'b00;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end

   // Zero-latency data path: the granted source is mirrored straight to the sink.
   always_comb begin
      In0Ready_SO = 1'b0;
      In1Ready_SO = 1'b0;
      OutValid_SO = 1'b0;
      OutSop_SO   = 1'b0;
      OutEop_SO   = 1'b0;
      OutEmpty_SO = 2'b00;
      OutError_SO = '0;
      OutData_DO  = '0;

      case (state_q)
         StBusy0: begin
            In0Ready_SO = OutReady_SI;
            OutValid_SO = In0Valid_SI;
            OutSop_SO   = In0Sop_SI;
            OutEop_SO   = In0Eop_SI;
            OutEmpty_SO = In0Empty_SI;
            OutError_SO = In0Error_SI;
            OutData_DO  = In0Data_DI;
         end
         StBusy1: begin
            In1Ready_SO = OutReady_SI;
            OutValid_SO = In1Valid_SI;
            OutSop_SO   = In1Sop_SI;
            OutEop_SO   = In1Eop_SI;
            OutEmpty_SO = In1Empty_SI;
            OutError_SO = In1Error_SI;
            OutData_DO  = In1Data_DI;
         end
         default: ;
      endcase
   end

   assign Grant_SO   = grant_q;
   assign PktCnt0_DO = cnt0_q;
   assign PktCnt1_DO = cnt1_q;

endmodule

// File: doc/avalon_st_pkt_arbiter.md
Name: avalon_st_pkt_arbiter

Overview:
- Shares one Avalon-ST sink between two Avalon-ST sources at packet granularity.
- Round-robin arbitration; the grant is locked from the first accepted beat until the Eop beat is accepted.
- Sits between two stream producers (for example, the header generator and the payload DMA) and the single downstream stream consumer.
- Ready latency 0 on all ports. Also provides per-input completed-packet counters for the CSR block.

Parameters:
- DATA_WIDTH, 32, width of Data on all stream ports.
- ERROR_WIDTH, 1, width of Error on all stream ports.
- CNT_WIDTH, 16, width of each packet counter.

Ports:
- Clk_CI  in  1  clock; single clock domain.
- Rst_RBI  in  1  reset; asynchronous assert, active-low.
- In0Valid_SI, In0Sop_SI, In0Eop_SI  in  1 each  source 0 stream control.
- In0Empty_SI  in  2  source 0 empty.
- In0Error_SI  in  ERROR_WIDTH  source 0 error.
- In0Data_DI  in  DATA_WIDTH  source 0 data.
- In0Ready_SO  out  1  ready to source 0.
- In1* (Valid, Sop, Eop, Empty, Error, Data, Ready)  same widths and directions as In0*  source 1.
- OutValid_SO, OutSop_SO, OutEop_SO  out  1 each  sink stream control.
- OutEmpty_SO  out  2  sink empty.
- OutError_SO  out  ERROR_WIDTH  sink error.
- OutData_DO  out  DATA_WIDTH  sink data.
- OutReady_SI  in  1  ready from sink.
- Grant_SO  out  2  one-hot current grant; 00 = idle.
- PktCnt0_DO, PktCnt1_DO  out  CNT_WIDTH  completed-packet counts for source 0 and source 1.

Behaviour:
- Reset (Rst_RBI low, asynchronous):
  - State = IDLE, Grant_SO = 00, LastGrant = 1 (so source 0 wins the first tie), PktCnt* = 0.
  - All Out* = 0, In*Ready_SO = 0.
- FSM states:
  - IDLE: no grant.
  - BUSY0: source 0 granted.
  - BUSY1: source 1 granted.
- IDLE transitions, evaluated on each clock edge:
  - Only In0Valid_SI high -> BUSY0.
  - Only In1Valid_SI high -> BUSY1.
  - Both high -> the source that is not LastGrant.
  - Neither high -> stay in IDLE.
  - LastGrant is updated when entering BUSYx.
  - Grant is registered, so the first beat passes one cycle after Valid is first seen.
- In IDLE:
  - OutValid_SO = 0; OutData_DO, OutSop_SO, OutEop_SO, OutEmpty_SO and OutError_SO all = 0.
  - Both In*Ready_SO = 0.
- In BUSYx (combinational path, zero added latency):
  - Out* mirrors Inx*.
  - InxReady_SO = OutReady_SI; the non-granted Ready = 0.
  - A beat is accepted when InxValid_SI & OutReady_SI.
- Exit from BUSYx:
  - An accepted beat with InxEop_SI = 1 -> IDLE on the next edge, and PktCntx increments by 1.
  - This gives a mandatory one-cycle bubble between packets, including back-to-back packets from the same source.
- Sop handling: Sop is not checked. Any valid beat seen in IDLE starts a grant. The block neither detects nor repairs protocol errors; it passes them through.
- Single-beat packets (Sop = Eop = 1): granted, forwarded in one accepted cycle, then return to IDLE.
- Valid deasserting mid-packet: the grant is held and the other source waits. There is no timeout.
- Backpressure: while OutReady_SI = 0, the granted source sees Ready = 0 and the FSM holds its state.
- Counters: unsigned, wrap from 2^CNT_WIDTH-1 to 0 without saturation. Counters are never cleared except by reset.
- Reset mid-packet: the block returns to IDLE immediately (asynchronously). The downstream packet is truncated; no Eop is generated.
- Grant_SO: BUSY0 = 01, BUSY1 = 10, IDLE = 00. Fully registered.

Test Plan:
1. Reset release, no traffic -> Grant_SO = 00, OutValid_SO = 0, In0Ready_SO = In1Ready_SO = 0, PktCnt0_DO = PktCnt1_DO = 0 for 10 cycles.
2. Source 0 sends a 4-beat packet (data 0x1..0x4) with OutReady_SI = 1 -> Grant_SO = 01 one cycle after Valid; 4 beats out in consecutive cycles with Sop on 0x1 and Eop on 0x4; back to IDLE; PktCnt0_DO = 1.
3. Both sources continuously offer 2-beat packets -> grants alternate 01, 10, 01, 10, starting with source 0; one idle cycle between packets; after 8 packets PktCnt0_DO = PktCnt1_DO = 4.
4. Source 1 is granted mid-packet, OutReady_SI toggles 1, 0, 0, 1 and source 0 is valid throughout -> no source-0 beat passes until source 1 Eop is accepted; no data duplicated or lost.
5. Single-beat packets (Sop = Eop = 1) from source 0 only, 5 times -> 5 outputs, each separated by one bubble; PktCnt0_DO = 5.
6. With CNT_WIDTH = 2, send 5 packets on source 1 -> PktCnt1_DO wraps to 1. Then assert Rst_RBI low mid-packet -> Grant_SO = 00 and OutValid_SO = 0 immediately; counters = 0.
